// File: rtl/branch_ctrl.sv
// Branch resolution, PC redirect and load-use bubble control for the 5-stage RV32I pipeline.
// Latency: all control outputs are combinational from EX/ID inputs; counters update at the next edge.
// Backpressure: stall holds PC and IF/ID for one cycle on a load-use hazard; a redirect flushes instead.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ex_valid/branch/jump  EX slot qualifiers (real instruction, conditional branch, JAL/JALR)
//   ex_funct3, ex_zero/lt/ltu   branch type and ALU compare flags for the EX instruction
//   ex_mem_read, ex_rd    EX instruction is a load, and its destination register
//   id_branch, id_rs1/rs2 ID instruction is a branch, and its source registers
//   pc_src, flush_if_id   redirect the PC and clear IF/ID (same cycle the branch resolves)
//   flush_id_ex, stall    insert a bubble into ID/EX; hold PC and IF/ID
//   branch_cnt, taken_cnt saturating counts of resolved branches/jumps and taken redirects
module branch_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_zero,
  input  logic             ex_lt,
  input  logic             ex_ltu,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_branch,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             pc_src,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             stall,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] branch_q;
  logic [CNT_W-1:0] taken_q;
  logic             cond;
  logic             take;
  logic             resolved;
  logic             load_use;
  logic             hold;

  // Reserved funct3 encodings (010/011) resolve as not taken.
  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      3'b000:  cond = ex_zero;
      3'b001:  cond = ~ex_zero;
      3'b100:  cond = ex_lt;
      3'b101:  cond = ~ex_lt;
      3'b110:  cond = ex_ltu;
      3'b111:  cond = ~ex_ltu;
      default: cond = 1'b0;
    endcase
  end

  // In FLUSH the EX slot holds the instruction squashed by the previous redirect,
  // so it can neither redirect nor be counted.
  assign resolved = ex_valid & (ex_branch | ex_jump) & (state == RUN);
  assign take     = ex_valid & (ex_jump | (ex_branch & cond)) & (state == RUN);

  // x0 is never a real dependency.
  assign load_use = id_branch & ex_mem_read & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // A redirect squashes the ID instruction anyway, so it wins over the stall.
  assign hold = load_use & ~take;

  assign pc_src      = ~reset & take;
  assign flush_if_id = ~reset & take;
  assign flush_id_ex = ~reset & (take | hold);
  assign stall       = ~reset & hold;
  assign branch_cnt  = reset ? '0 : branch_q;
  assign taken_cnt   = reset ? '0 : taken_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      branch_q <= '0;
      taken_q  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (resolved && (branch_q != {CNT_W{1'b1}})) branch_q <= branch_q + 1'b1;
          if (take && (taken_q != {CNT_W{1'b1}}))      taken_q  <= taken_q + 1'b1;
          state <= take ? FLUSH : RUN;
        end
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ex_valid, ex_branch, ex_jump, ex_zero, ex_lt, ex_ltu, ex_mem_read, id_branch;
  logic [2:0] ex_funct3;
  logic [4:0] ex_rd, id_rs1, id_rs2;

  logic        pc_src, flush_if_id, flush_id_ex, stall;
  logic [15:0] branch_cnt, taken_cnt;
  logic        pc_src4, flush_if_id4, flush_id_ex4, stall4;
  logic [3:0]  branch_cnt4, taken_cnt4;

  int errors = 0;
  int checks = 0;

  // Reference state: "the previous cycle redirected" plus unbounded event counts.
  bit m_flush;
  int m_b, m_t;

  always #5 clk = ~clk;

  branch_ctrl dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_branch(id_branch), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .pc_src(pc_src), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall(stall), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_ctrl #(.CNT_W(4), .REG_W(5)) dut4 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_branch(id_branch), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .pc_src(pc_src4), .flush_if_id(flush_if_id4), .flush_id_ex(flush_id_ex4),
    .stall(stall4), .branch_cnt(branch_cnt4), .taken_cnt(taken_cnt4)
  );

  // ---------------- reference model ----------------
  function automatic bit cond_of(logic [2:0] f, logic z, logic lt, logic ltu);
    case (f)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_take();
    return ex_valid && (ex_jump || (ex_branch && cond_of(ex_funct3, ex_zero, ex_lt, ex_ltu)))
           && !m_flush;
  endfunction

  // {pc_src, flush_if_id, flush_id_ex, stall}
  function automatic logic [3:0] m_out();
    bit tk, lu;
    tk = m_take();
    lu = id_branch && ex_mem_read && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (reset) return 4'b0000;
    return {tk, tk, tk || lu, lu && !tk};
  endfunction

  function automatic int sat(int v, int m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic [47:0] exp_vec();
    logic [3:0] o;
    int b, t;
    o = m_out();
    b = reset ? 0 : m_b;
    t = reset ? 0 : m_t;
    return {o, o, 16'(sat(b, 65535)), 16'(sat(t, 65535)), 4'(sat(b, 15)), 4'(sat(t, 15))};
  endfunction

  function automatic logic [47:0] got();
    return {pc_src, flush_if_id, flush_id_ex, stall, pc_src4, flush_if_id4, flush_id_ex4, stall4,
            branch_cnt, taken_cnt, branch_cnt4, taken_cnt4};
  endfunction

  // Advance the model across a rising edge using the inputs present at that edge.
  task automatic tick();
    bit tk;
    @(posedge clk);
    tk = m_take();
    if (reset) begin
      m_flush = 0; m_b = 0; m_t = 0;
    end else if (m_flush) begin
      m_flush = 0;
    end else begin
      if (ex_valid && (ex_branch || ex_jump)) m_b++;
      if (tk) m_t++;
      m_flush = tk;
    end
    #1;
  endtask

  task automatic set_idle();
    ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_funct3 = 0; ex_zero = 0; ex_lt = 0; ex_ltu = 0;
    ex_mem_read = 0; ex_rd = 0; id_branch = 0; id_rs1 = 0; id_rs2 = 0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    reset = 1;
    ex_valid = 1; ex_branch = 1; ex_funct3 = 3'd0; ex_zero = 1;
    ex_mem_read = 1; ex_rd = 5'd3; id_branch = 1; id_rs1 = 5'd3;
    @(negedge clk);
    checks++;
    if (got() !== 48'h0) begin
      errors++; $display("FAIL reset_forced_zero: got %h want 0", got());
    end
    tick();
    reset = 0;
    set_idle();
    @(negedge clk);
    checks++;
    if (got() !== exp_vec()) begin
      errors++; $display("FAIL reset_idle: got %h want %h", got(), exp_vec());
    end
  endtask

  task automatic test_beq_taken();
    do_reset();
    ex_valid = 1; ex_branch = 1; ex_funct3 = 3'b000; ex_zero = 1;
    @(negedge clk);
    checks++;
    if ({pc_src, flush_if_id, flush_id_ex, stall} !== 4'b1110) begin
      errors++; $display("FAIL beq_resolve: got %b want 1110", {pc_src, flush_if_id, flush_id_ex, stall});
    end
    checks++;
    if (got() !== exp_vec()) begin
      errors++; $display("FAIL beq_resolve_model: got %h want %h", got(), exp_vec());
    end
    tick();
    @(negedge clk);
    checks++;
    if ({pc_src, flush_if_id, flush_id_ex, stall, branch_cnt, taken_cnt} !== {4'b0000, 16'd1, 16'd1}) begin
      errors++; $display("FAIL beq_flush_cycle: got %b/%0d/%0d want 0000/1/1",
                         {pc_src, flush_if_id, flush_id_ex, stall}, branch_cnt, taken_cnt);
    end
  endtask

  task automatic test_not_taken();
    logic [2:0] f   [3] = '{3'b001, 3'b111, 3'b010};
    logic       z   [3] = '{1'b1, 1'b0, 1'b1};
    logic       ltu [3] = '{1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1; ex_branch = 1; ex_funct3 = f[i]; ex_zero = z[i]; ex_ltu = ltu[i]; ex_lt = 1;
      @(negedge clk);
      checks++;
      if (pc_src !== 1'b0 || got() !== exp_vec()) begin
        errors++; $display("FAIL not_taken_%0d: got %h want %h", i, got(), exp_vec());
      end
      tick();
    end
    set_idle();
    @(negedge clk);
    checks++;
    if (branch_cnt !== 16'd3 || taken_cnt !== 16'd0) begin
      errors++; $display("FAIL not_taken_counts: got %0d/%0d want 3/0", branch_cnt, taken_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1; ex_rd = 5'd5; id_branch = 1; id_rs1 = 5'd1; id_rs2 = 5'd5;
    @(negedge clk);
    checks++;
    if ({pc_src, flush_if_id, flush_id_ex, stall} !== 4'b0011) begin
      errors++; $display("FAIL load_use_stall: got %b want 0011", {pc_src, flush_if_id, flush_id_ex, stall});
    end
    ex_rd = 5'd0; id_rs2 = 5'd0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || flush_id_ex !== 1'b0) begin
      errors++; $display("FAIL load_use_x0: got stall=%b flush_id_ex=%b want 0 0", stall, flush_id_ex);
    end
  endtask

  task automatic test_jump_overrides();
    do_reset();
    ex_mem_read = 1; ex_rd = 5'd7; id_branch = 1; id_rs1 = 5'd7;
    ex_valid = 1; ex_jump = 1;
    @(negedge clk);
    checks++;
    if ({pc_src, flush_if_id, flush_id_ex, stall} !== 4'b1110) begin
      errors++; $display("FAIL jump_over_stall: got %b want 1110", {pc_src, flush_if_id, flush_id_ex, stall});
    end
    tick();
    @(negedge clk);
    checks++;
    if (pc_src !== 1'b0 || taken_cnt !== 16'd1 || got() !== exp_vec()) begin
      errors++; $display("FAIL jump_in_flush: got %h want %h", got(), exp_vec());
    end
  endtask

  task automatic test_saturate();
    do_reset();
    ex_valid = 1; ex_jump = 1;
    for (int i = 0; i < 21; i++) begin
      tick();   // resolve in RUN
      tick();   // FLUSH slot
    end
    @(negedge clk);
    checks++;
    if (taken_cnt4 !== 4'd15 || branch_cnt4 !== 4'd15) begin
      errors++; $display("FAIL sat_cnt4: got %0d/%0d want 15/15", branch_cnt4, taken_cnt4);
    end
    checks++;
    if (branch_cnt !== 16'd21 || taken_cnt !== 16'd21 || got() !== exp_vec()) begin
      errors++; $display("FAIL sat_cnt16: got %h want %h", got(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    ex_valid = 1; ex_branch = 1; ex_funct3 = 3'b000; ex_zero = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      tick();
    end
    // Now in the FLUSH cycle after the third taken branch.
    reset = 1;
    @(negedge clk);
    checks++;
    if (got() !== 48'h0) begin
      errors++; $display("FAIL reset_in_flush_outputs: got %h want 0", got());
    end
    tick();
    reset = 0;
    @(negedge clk);
    checks++;
    if ({pc_src, flush_if_id, flush_id_ex, stall, branch_cnt, taken_cnt} !== {4'b1110, 16'd0, 16'd0}) begin
      errors++; $display("FAIL beq_after_reset: got %b/%0d/%0d want 1110/0/0",
                         {pc_src, flush_if_id, flush_id_ex, stall}, branch_cnt, taken_cnt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (branch_cnt !== 16'd1 || taken_cnt !== 16'd1 || got() !== exp_vec()) begin
      errors++; $display("FAIL counts_after_reset: got %h want %h", got(), exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 40) == 0);
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_branch   = $urandom_range(0, 1);
      ex_jump     = ($urandom_range(0, 4) == 0);
      ex_funct3   = 3'($urandom_range(0, 7));
      ex_zero     = $urandom_range(0, 1);
      ex_lt       = $urandom_range(0, 1);
      ex_ltu      = $urandom_range(0, 1);
      ex_mem_read = $urandom_range(0, 1);
      ex_rd       = 5'($urandom_range(0, 3));
      id_branch   = $urandom_range(0, 1);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      @(negedge clk);
      checks++;
      if (got() !== exp_vec()) begin
        errors++; $display("FAIL random_%0d: got %h want %h", i, got(), exp_vec());
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    m_flush = 0; m_b = 0; m_t = 0;
    set_idle();
    test_reset();
    test_beq_taken();
    test_not_taken();
    test_load_use();
    test_jump_overrides();
    test_saturate();
    test_reset_mid_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
